// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode-stage operand path: ID state encoding,
// instruction field positions and the hard-wired zero register.
package id_operand_stage_pkg;

   // Occupancy of the ID stage.
   // EMPTY: nothing held. FRESH: word is on the SRAM bus this cycle.
   // HELD: word has been copied into the hold buffer.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FRESH = 2'd1,
      ST_HELD  = 2'd2
   } id_state_t;

   localparam int RF_AW_DEF = 5;   // default register address width
   localparam int INST_W    = 32;  // instruction word width
   localparam int RS_LSB    = 21;  // rs field is inst[25:21]
   localparam int RT_LSB    = 16;  // rt field is inst[20:16]
   localparam int ZERO_REG  = 0;   // register that always reads as zero

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Single-operand priority bypass. Source 0 is the youngest producer and wins
// over every older source that targets the same register. Register 0 is
// never forwarded and always reads as zero.
module id_operand_stage_fwd_select
   import id_operand_stage_pkg::*;
#(
   parameter int NUM_FWD = 3,
   parameter int DATA_W  = 32,
   parameter int RF_AW   = RF_AW_DEF
) (
   input  logic [RF_AW-1:0]          raddr,
   input  logic [DATA_W-1:0]         rf_rdata,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   output logic [DATA_W-1:0]         data,
   output logic                      pending
);

   logic found;

   // Pick the lowest-index matching source, fall back to the regfile.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned (which would infer a latch); blocking '=' is the right
      // assignment inside combinational logic.
      data    = rf_rdata;
      pending = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (!found && fwd_we[i] && (fwd_waddr[i*RF_AW +: RF_AW] == raddr)) begin
            found   = 1'b1;
            data    = fwd_wdata[i*DATA_W +: DATA_W];
            pending = fwd_pending[i];
         end
      end
      if (raddr == RF_AW'(ZERO_REG)) begin
         data    = '0;
         pending = 1'b0;
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// IF->ID pipeline register with valid/ready handshake, instruction hold
// buffer for the 1-cycle-latency instruction SRAM, two-operand priority
// bypass and load-use interlock. Operands are combinational from ID state.
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 32,
   parameter int NUM_FWD = 3,
   parameter int RF_AW   = RF_AW_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [PC_W-1:0]           in_pc,
   output logic                      in_ready,
   input  logic                      flush,
   input  logic [INST_W-1:0]         inst_rdata,
   output logic [RF_AW-1:0]          rf_raddr1,
   output logic [RF_AW-1:0]          rf_raddr2,
   input  logic [DATA_W-1:0]         rf_rdata1,
   input  logic [DATA_W-1:0]         rf_rdata2,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_pending,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PC_W-1:0]           out_pc,
   output logic [INST_W-1:0]         out_inst,
   output logic [DATA_W-1:0]         out_op1,
   output logic [DATA_W-1:0]         out_op2,
   output logic                      stallreq
);

   id_state_t          state;
   logic [PC_W-1:0]    pc_r;
   logic [INST_W-1:0]  hold_r;
   logic               pend1;
   logic               pend2;
   logic               fire;
   logic               capture;

   // Present the live SRAM word on the first cycle, the buffered copy after.
   always_comb begin
      out_inst = '0;
      unique case (state)
         ST_FRESH: out_inst = inst_rdata;
         ST_HELD:  out_inst = hold_r;
         default:  out_inst = '0;
      endcase
   end

   assign rf_raddr1 = out_inst[RS_LSB +: RF_AW];
   assign rf_raddr2 = out_inst[RT_LSB +: RF_AW];
   assign out_pc    = pc_r;

   id_operand_stage_fwd_select #(
      .NUM_FWD (NUM_FWD),
      .DATA_W  (DATA_W),
      .RF_AW   (RF_AW)
   ) u_fwd_rs (
      .raddr       (rf_raddr1),
      .rf_rdata    (rf_rdata1),
      .fwd_we      (fwd_we),
      .fwd_waddr   (fwd_waddr),
      .fwd_wdata   (fwd_wdata),
      .fwd_pending (fwd_pending),
      .data        (out_op1),
      .pending     (pend1)
   );

   id_operand_stage_fwd_select #(
      .NUM_FWD (NUM_FWD),
      .DATA_W  (DATA_W),
      .RF_AW   (RF_AW)
   ) u_fwd_rt (
      .raddr       (rf_raddr2),
      .rf_rdata    (rf_rdata2),
      .fwd_we      (fwd_we),
      .fwd_waddr   (fwd_waddr),
      .fwd_wdata   (fwd_wdata),
      .fwd_pending (fwd_pending),
      .data        (out_op2),
      .pending     (pend2)
   );

   // Only the winning source's pending flag matters; shadowed ones are ignored.
   assign stallreq  = (state != ST_EMPTY) && (pend1 || pend2);
   assign out_valid = (state != ST_EMPTY) && !stallreq && !flush;
   assign fire      = out_valid && out_ready;
   assign in_ready  = (state == ST_EMPTY) || fire;
   assign capture   = in_valid && in_ready && !flush;

   // Occupancy FSM, pc register and hold buffer; flush beats capture.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values; the hold buffer is reset too so out_inst
      // is deterministic from the first cycle.
      if (!rst) begin
         state  <= ST_EMPTY;
         pc_r   <= '0;
         hold_r <= '0;
      end else if (flush) begin
         state <= ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (capture) begin
                  state <= ST_FRESH;
                  pc_r  <= in_pc;
               end
            end
            ST_FRESH, ST_HELD: begin
               if (fire) begin
                  if (capture) begin
                     state <= ST_FRESH;
                     pc_r  <= in_pc;
                  end else begin
                     state <= ST_EMPTY;
                  end
               end else if (state == ST_FRESH) begin
                  hold_r <= inst_rdata;
                  state  <= ST_HELD;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed self-checking bench for id_operand_stage.
module tb_id_operand_stage;

   localparam int DATA_W  = 32;
   localparam int PC_W    = 32;
   localparam int NUM_FWD = 3;
   localparam int RF_AW   = 5;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic [PC_W-1:0]           in_pc;
   logic                      in_ready;
   logic                      flush;
   logic [31:0]               inst_rdata;
   logic [RF_AW-1:0]          rf_raddr1;
   logic [RF_AW-1:0]          rf_raddr2;
   logic [DATA_W-1:0]         rf_rdata1;
   logic [DATA_W-1:0]         rf_rdata2;
   logic [NUM_FWD-1:0]        fwd_we;
   logic [NUM_FWD*RF_AW-1:0]  fwd_waddr;
   logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
   logic [NUM_FWD-1:0]        fwd_pending;
   logic                      out_valid;
   logic                      out_ready;
   logic [PC_W-1:0]           out_pc;
   logic [31:0]               out_inst;
   logic [DATA_W-1:0]         out_op1;
   logic [DATA_W-1:0]         out_op2;
   logic                      stallreq;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_operand_stage #(
      .DATA_W  (DATA_W),
      .PC_W    (PC_W),
      .NUM_FWD (NUM_FWD),
      .RF_AW   (RF_AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_pc       (in_pc),
      .in_ready    (in_ready),
      .flush       (flush),
      .inst_rdata  (inst_rdata),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .fwd_we      (fwd_we),
      .fwd_waddr   (fwd_waddr),
      .fwd_wdata   (fwd_wdata),
      .fwd_pending (fwd_pending),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst),
      .out_op1     (out_op1),
      .out_op2     (out_op2),
      .stallreq    (stallreq)
   );

   // Advance one clock; inputs are then driven / outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd();
      fwd_we      = '0;
      fwd_waddr   = '0;
      fwd_wdata   = '0;
      fwd_pending = '0;
   endtask

   // From EMPTY: capture pc, deliver word, stall one cycle so it lands in HELD.
   task automatic load_held(input logic [PC_W-1:0] pc, input logic [31:0] inst);
      in_valid  = 1'b1;
      in_pc     = pc;
      out_ready = 1'b0;
      tick();
      in_valid   = 1'b0;
      inst_rdata = inst;
      tick();
      inst_rdata = 32'hDEAD_BEEF;
      #1;
   endtask

   // Let the held instruction fire and return to EMPTY.
   task automatic drain();
      clear_fwd();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
      inst_rdata = 32'h1234_5678; rf_rdata1 = '0; rf_rdata2 = '0;
      clear_fwd();
      tick();
      tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      vectors++;
      if (stallreq !== 1'b0) begin miscompares++; $display("FAIL reset_stallreq got %0b want 0", stallreq); end
      vectors++;
      if (out_inst !== 32'h0) begin miscompares++; $display("FAIL reset_out_inst got %h want 00000000", out_inst); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      vectors++;
      if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h want 00000000", out_pc); end
   endtask

   task automatic test_back_to_back();
      rf_rdata1 = 32'h55; rf_rdata2 = 32'h66;
      in_valid = 1'b1; in_pc = 32'h100; out_ready = 1'b1;
      tick();
      inst_rdata = 32'h2402_0005;
      in_pc      = 32'h104;
      #1;
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid0 got %0b want 1", out_valid); end
      vectors++;
      if (out_inst !== 32'h2402_0005) begin miscompares++; $display("FAIL b2b_inst0 got %h want 24020005", out_inst); end
      vectors++;
      if (out_pc !== 32'h100) begin miscompares++; $display("FAIL b2b_pc0 got %h want 00000100", out_pc); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got %0b want 1", in_ready); end
      vectors++;
      if (rf_raddr2 !== 5'd2) begin miscompares++; $display("FAIL b2b_raddr2 got %0d want 2", rf_raddr2); end
      vectors++;
      if (out_op1 !== 32'h0) begin miscompares++; $display("FAIL b2b_op1_r0 got %h want 00000000", out_op1); end
      vectors++;
      if (out_op2 !== 32'h66) begin miscompares++; $display("FAIL b2b_op2_rf got %h want 00000066", out_op2); end
      tick();
      in_valid   = 1'b0;
      inst_rdata = 32'h0043_0821;
      #1;
      vectors++;
      if (out_pc !== 32'h104) begin miscompares++; $display("FAIL b2b_pc1 got %h want 00000104", out_pc); end
      vectors++;
      if (out_inst !== 32'h0043_0821) begin miscompares++; $display("FAIL b2b_inst1 got %h want 00430821", out_inst); end
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid1 got %0b want 1", out_valid); end
      tick();
      out_ready = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
   endtask

   task automatic test_hold();
      in_valid = 1'b1; in_pc = 32'h200; out_ready = 1'b0;
      tick();
      in_valid   = 1'b0;
      inst_rdata = 32'h0043_0821;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready got %0b want 0", in_ready); end
      for (int c = 0; c < 3; c++) begin
         tick();
         inst_rdata = 32'hDEAD_BEEF;
         #1;
         vectors++;
         if (out_inst !== 32'h0043_0821) begin miscompares++; $display("FAIL hold_inst[%0d] got %h want 00430821", c, out_inst); end
         vectors++;
         if (out_pc !== 32'h200) begin miscompares++; $display("FAIL hold_pc[%0d] got %h want 00000200", c, out_pc); end
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_fire got %0b want 1", in_ready); end
      tick();
      out_ready = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_drained got %0b want 0", out_valid); end
   endtask

   task automatic test_bypass();
      load_held(32'h300, 32'h0043_0821);  // rs=2, rt=3
      rf_rdata1 = 32'h44;
      fwd_we    = 3'b101;
      fwd_waddr = {5'd2, 5'd0, 5'd2};
      fwd_wdata = {32'h33, 32'h22, 32'h11};
      #1;
      vectors++;
      if (out_op1 !== 32'h11) begin miscompares++; $display("FAIL byp_youngest got %h want 00000011", out_op1); end
      fwd_we = 3'b100;
      #1;
      vectors++;
      if (out_op1 !== 32'h33) begin miscompares++; $display("FAIL byp_older got %h want 00000033", out_op1); end
      fwd_we = 3'b000;
      #1;
      vectors++;
      if (out_op1 !== 32'h44) begin miscompares++; $display("FAIL byp_rf got %h want 00000044", out_op1); end
      drain();
      load_held(32'h304, 32'h2402_0005);  // rs=0
      fwd_we    = 3'b001;
      fwd_waddr = {5'd0, 5'd0, 5'd0};
      fwd_wdata = {32'h0, 32'h0, 32'h99};
      #1;
      vectors++;
      if (out_op1 !== 32'h0) begin miscompares++; $display("FAIL byp_r0 got %h want 00000000", out_op1); end
      drain();
   endtask

   task automatic test_interlock();
      load_held(32'h400, 32'h0043_0821);  // rt=3
      rf_rdata2   = 32'h66;
      out_ready   = 1'b1;
      fwd_we      = 3'b001;
      fwd_waddr   = {5'd0, 5'd0, 5'd3};
      fwd_wdata   = {32'h0, 32'h0, 32'hFF};
      fwd_pending = 3'b001;
      #1;
      vectors++;
      if (stallreq !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %0b want 1", stallreq); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lu_valid got %0b want 0", out_valid); end
      out_ready = 1'b0;
      tick();  // must remain held across the stall
      vectors++;
      if (out_inst !== 32'h0043_0821) begin miscompares++; $display("FAIL lu_inst got %h want 00430821", out_inst); end
      fwd_pending = 3'b000;
      fwd_wdata   = {32'h0, 32'h0, 32'h7};
      #1;
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lu_resolved got %0b want 1", out_valid); end
      vectors++;
      if (out_op2 !== 32'h7) begin miscompares++; $display("FAIL lu_op2 got %h want 00000007", out_op2); end
      fwd_we      = 3'b011;
      fwd_waddr   = {5'd0, 5'd3, 5'd3};
      fwd_wdata   = {32'h0, 32'h9, 32'h8};
      fwd_pending = 3'b010;
      #1;
      vectors++;
      if (stallreq !== 1'b0) begin miscompares++; $display("FAIL lu_shadow got %0b want 0", stallreq); end
      vectors++;
      if (out_op2 !== 32'h8) begin miscompares++; $display("FAIL lu_shadow_op2 got %h want 00000008", out_op2); end
      fwd_we = 3'b010;
      #1;
      vectors++;
      if (stallreq !== 1'b1) begin miscompares++; $display("FAIL lu_older got %0b want 1", stallreq); end
      drain();
   endtask

   task automatic test_flush_reset();
      load_held(32'h500, 32'h0043_0821);
      in_valid = 1'b1; in_pc = 32'h504; flush = 1'b1; out_ready = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_cycle got %0b want 0", out_valid); end
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_empty got %0b want 0", out_valid); end
      vectors++;
      if (out_pc !== 32'h500) begin miscompares++; $display("FAIL fl_nocapture got %h want 00000500", out_pc); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fl_in_ready got %0b want 1", in_ready); end
      in_valid = 1'b1; in_pc = 32'h600;
      tick();
      in_valid   = 1'b0;
      inst_rdata = 32'h2402_0005;
      #1;
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rs_fresh got %0b want 1", out_valid); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid got %0b want 0", out_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rs_in_ready got %0b want 1", in_ready); end
      vectors++;
      if (out_pc !== 32'h0) begin miscompares++; $display("FAIL rs_pc got %h want 00000000", out_pc); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_hold();
      test_bypass();
      test_interlock();
      test_flush_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
